simple_dma: RTL and testbench

SIMPLE_DMA -- requirements
Module: simple_dma

---
 rtl/simple_dma_pkg.sv | 41 ++++
 rtl/simple_dma_regs.sv | 124 ++++++++++++
 rtl/simple_dma.sv | 153 +++++++++++++++
 tb/tb_simple_dma.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_dma_pkg.sv
// Shared constants, state encoding and helpers for the simple_dma block.
package simple_dma_pkg;

   localparam int unsigned DataWidth = 32;
   localparam int unsigned BeWidth   = 4;
   localparam int unsigned OffWidth  = 3;

   // Word offsets decoded from cfg_addr_i[4:2]
   localparam logic [OffWidth-1:0] OffSrc    = 3'd0;
   localparam logic [OffWidth-1:0] OffDst    = 3'd1;
   localparam logic [OffWidth-1:0] OffLen    = 3'd2;
   localparam logic [OffWidth-1:0] OffCtrl   = 3'd3;
   localparam logic [OffWidth-1:0] OffStatus = 3'd4;

   localparam int unsigned CtrlStartBit = 0;
   localparam int unsigned CtrlIrqEnBit = 1;
   localparam int unsigned StatBusyBit  = 0;
   localparam int unsigned StatDoneBit  = 1;
   localparam int unsigned StatErrBit   = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_WR_WAIT
   } dma_state_e;

   // Byte-lane merge of a write into an existing register value
   function automatic logic [DataWidth-1:0] be_merge(input logic [DataWidth-1:0] old_val,
                                                     input logic [DataWidth-1:0] new_val,
                                                     input logic [BeWidth-1:0]   be);
      logic [DataWidth-1:0] res;
      res = old_val;
      for (int i = 0; i < int'(BeWidth); i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/simple_dma_regs.sv
// Config register file: address decode, byte-enable writes, W1C status, irq.
module simple_dma_regs
   import simple_dma_pkg::*;
#(
   parameter int unsigned LenWidth     = 16,
   parameter logic        IrqEnDefault = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_req_i,
   input  logic                 cfg_we_i,
   input  logic [BeWidth-1:0]   cfg_be_i,
   input  logic [DataWidth-1:0] cfg_addr_i,
   input  logic [DataWidth-1:0] cfg_wdata_i,
   output logic                 cfg_rvalid_o,
   output logic [DataWidth-1:0] cfg_rdata_o,
   output logic                 cfg_err_o,
   input  logic                 busy_i,
   input  logic                 set_done_i,
   input  logic                 set_err_i,
   input  logic                 clr_status_i,
   output logic                 start_c,
   output logic [DataWidth-1:0] src_o,
   output logic [DataWidth-1:0] dst_o,
   output logic [LenWidth-1:0]  len_o,
   output logic                 irq_o
);

   logic [DataWidth-1:0] src_q, src_d, dst_q, dst_d, rdata_d;
   logic [LenWidth-1:0]  len_q, len_d;
   logic                 irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, cerr_d;
   logic [OffWidth-1:0]  off;
   logic                 unused_addr;

   assign off         = cfg_addr_i[4:2];
   assign unused_addr = ^{cfg_addr_i[DataWidth-1:5], cfg_addr_i[1:0]};
   assign src_o       = src_q;
   assign dst_o       = dst_q;
   assign len_o       = len_q;

   // Decode and next-value logic; engine set events win over W1C
   always_comb begin
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      err_d    = err_q;
      rdata_d  = '0;
      cerr_d   = 1'b0;
      start_c  = 1'b0;
      if (cfg_req_i) begin
         case (off)
            OffSrc: begin
               if (!cfg_we_i)   rdata_d = src_q;
               else if (busy_i) cerr_d  = 1'b1;
               else src_d = be_merge(src_q, cfg_wdata_i, cfg_be_i) & ~DataWidth'(3);
            end
            OffDst: begin
               if (!cfg_we_i)   rdata_d = dst_q;
               else if (busy_i) cerr_d  = 1'b1;
               else dst_d = be_merge(dst_q, cfg_wdata_i, cfg_be_i) & ~DataWidth'(3);
            end
            OffLen: begin
               if (!cfg_we_i)   rdata_d = DataWidth'(len_q);
               else if (busy_i) cerr_d  = 1'b1;
               else len_d = LenWidth'(be_merge(DataWidth'(len_q), cfg_wdata_i, cfg_be_i));
            end
            OffCtrl: begin
               if (!cfg_we_i) begin
                  rdata_d[CtrlIrqEnBit] = irq_en_q;
               end else if (cfg_be_i[0]) begin
                  irq_en_d = cfg_wdata_i[CtrlIrqEnBit];
                  start_c  = cfg_wdata_i[CtrlStartBit];
               end
            end
            OffStatus: begin
               if (!cfg_we_i) begin
                  rdata_d[StatBusyBit] = busy_i;
                  rdata_d[StatDoneBit] = done_q;
                  rdata_d[StatErrBit]  = err_q;
               end else if (cfg_be_i[0]) begin
                  if (cfg_wdata_i[StatDoneBit]) done_d = 1'b0;
                  if (cfg_wdata_i[StatErrBit])  err_d  = 1'b0;
               end
            end
            default: cerr_d = 1'b1;
         endcase
      end
      if (clr_status_i) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end
      if (set_done_i) done_d = 1'b1;
      if (set_err_i)  err_d  = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         irq_en_q     <= IrqEnDefault;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cfg_rvalid_o <= 1'b0;
         cfg_rdata_o  <= '0;
         cfg_err_o    <= 1'b0;
         irq_o        <= 1'b0;
      end else begin
         src_q        <= src_d;
         dst_q        <= dst_d;
         len_q        <= len_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cfg_rvalid_o <= cfg_req_i;
         cfg_rdata_o  <= rdata_d;
         cfg_err_o    <= cerr_d;
         irq_o        <= done_d & irq_en_d;
      end
   end

endmodule

// File: rtl/simple_dma.sv
// Single-channel word copy engine: read one word, write it, repeat LEN times.
module simple_dma
   import simple_dma_pkg::*;
#(
   parameter int unsigned LenWidth     = 16,
   parameter logic        IrqEnDefault = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_req_i,
   input  logic                 cfg_we_i,
   input  logic [BeWidth-1:0]   cfg_be_i,
   input  logic [DataWidth-1:0] cfg_addr_i,
   input  logic [DataWidth-1:0] cfg_wdata_i,
   output logic                 cfg_rvalid_o,
   output logic [DataWidth-1:0] cfg_rdata_o,
   output logic                 cfg_err_o,
   output logic                 host_req_o,
   input  logic                 host_gnt_i,
   output logic [DataWidth-1:0] host_addr_o,
   output logic                 host_we_o,
   output logic [BeWidth-1:0]   host_be_o,
   output logic [DataWidth-1:0] host_wdata_o,
   input  logic                 host_rvalid_i,
   input  logic [DataWidth-1:0] host_rdata_i,
   input  logic                 host_err_i,
   output logic                 irq_o
);

   dma_state_e           state_q, state_d;
   logic [DataWidth-1:0] wsrc_q, wsrc_d, wdst_q, wdst_d, buf_q, buf_d;
   logic [LenWidth-1:0]  cnt_q, cnt_d;
   logic                 busy_q, start_c, set_done, set_err, clr_status;
   logic [DataWidth-1:0] reg_src, reg_dst;
   logic [LenWidth-1:0]  reg_len;

   simple_dma_regs #(
      .LenWidth     (LenWidth),
      .IrqEnDefault (IrqEnDefault)
   ) u_regs (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cfg_req_i    (cfg_req_i),
      .cfg_we_i     (cfg_we_i),
      .cfg_be_i     (cfg_be_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_wdata_i  (cfg_wdata_i),
      .cfg_rvalid_o (cfg_rvalid_o),
      .cfg_rdata_o  (cfg_rdata_o),
      .cfg_err_o    (cfg_err_o),
      .busy_i       (busy_q),
      .set_done_i   (set_done),
      .set_err_i    (set_err),
      .clr_status_i (clr_status),
      .start_c      (start_c),
      .src_o        (reg_src),
      .dst_o        (reg_dst),
      .len_o        (reg_len),
      .irq_o        (irq_o)
   );

   // Engine next-state; one bus transaction in flight at most
   always_comb begin
      state_d    = state_q;
      wsrc_d     = wsrc_q;
      wdst_d     = wdst_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      set_done   = 1'b0;
      set_err    = 1'b0;
      clr_status = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               if (reg_len == '0) begin
                  set_done = 1'b1;
               end else begin
                  wsrc_d     = reg_src;
                  wdst_d     = reg_dst;
                  cnt_d      = reg_len;
                  clr_status = 1'b1;
                  state_d    = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: if (host_gnt_i) state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (host_rvalid_i) begin
               if (host_err_i) begin
                  set_err  = 1'b1;
                  set_done = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  buf_d   = host_rdata_i;
                  state_d = S_WR_REQ;
               end
            end
         end
         S_WR_REQ: if (host_gnt_i) state_d = S_WR_WAIT;
         S_WR_WAIT: begin
            if (host_rvalid_i) begin
               if (host_err_i) begin
                  set_err  = 1'b1;
                  set_done = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  wsrc_d = wsrc_q + DataWidth'(4);
                  wdst_d = wdst_q + DataWidth'(4);
                  cnt_d  = cnt_q - LenWidth'(1);
                  if (cnt_q == LenWidth'(1)) begin
                     set_done = 1'b1;
                     state_d  = S_IDLE;
                  end else begin
                     state_d = S_RD_REQ;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Host outputs are registered from the next state so they align with it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         wsrc_q       <= '0;
         wdst_q       <= '0;
         cnt_q        <= '0;
         buf_q        <= '0;
         busy_q       <= 1'b0;
         host_req_o   <= 1'b0;
         host_we_o    <= 1'b0;
         host_be_o    <= '0;
         host_addr_o  <= '0;
         host_wdata_o <= '0;
      end else begin
         state_q      <= state_d;
         wsrc_q       <= wsrc_d;
         wdst_q       <= wdst_d;
         cnt_q        <= cnt_d;
         buf_q        <= buf_d;
         busy_q       <= (state_d != S_IDLE);
         host_req_o   <= (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
         host_we_o    <= (state_d == S_WR_REQ);
         host_be_o    <= ((state_d == S_RD_REQ) || (state_d == S_WR_REQ)) ? 4'hF : 4'h0;
         host_addr_o  <= (state_d == S_RD_REQ) ? wsrc_d :
                         (state_d == S_WR_REQ) ? wdst_d : '0;
         host_wdata_o <= (state_d == S_WR_REQ) ? buf_d : '0;
      end
   end

endmodule

// File: tb/tb_simple_dma.sv
// Directed bench for simple_dma with a reactive memory-backed host bus responder.
module tb_simple_dma;

   logic        clk_i, rst_i;
   logic        cfg_req_i, cfg_we_i;
   logic [3:0]  cfg_be_i;
   logic [31:0] cfg_addr_i, cfg_wdata_i;
   logic        cfg_rvalid_o, cfg_err_o;
   logic [31:0] cfg_rdata_o;
   logic        host_req_o, host_gnt_i, host_we_o, host_rvalid_i, host_err_i;
   logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
   logic [3:0]  host_be_o;
   logic        irq_o;

   int checks, errors;
   int gnt_max, rv_extra, err_read_n, read_cnt, stab_err;
   logic [31:0] log_addr[$];
   logic        log_we[$];
   logic [31:0] log_wdata[$];
   logic [31:0] mem [logic [31:0]];

   simple_dma dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_be_i(cfg_be_i),
      .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
      .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
      .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
      .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
      .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
      .irq_o(irq_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   // Host bus responder: grants after 0..gnt_max cycles, answers rvalid one cycle after gnt
   initial begin : responder
      int wait_left, pend_wait;
      logic pend, pend_err, holding, h_we;
      logic [31:0] pend_data, h_addr, h_wdata;
      host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = 0;
      pend = 0; pend_err = 0; pend_data = 0; holding = 0; h_we = 0; h_addr = 0; h_wdata = 0;
      wait_left = 0; pend_wait = 0;
      forever begin
         @(negedge clk_i);
         host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = 0;
         if (pend) begin
            if (pend_wait > 0) pend_wait--;
            else begin
               host_rvalid_i = 1; host_rdata_i = pend_data; host_err_i = pend_err; pend = 0;
            end
         end
         if (host_req_o === 1'b1) begin
            if (!holding) begin
               holding = 1; h_addr = host_addr_o; h_we = host_we_o; h_wdata = host_wdata_o;
               wait_left = (gnt_max > 0) ? int'($urandom_range(gnt_max, 0)) : 0;
            end else if (host_addr_o !== h_addr || host_we_o !== h_we ||
                         host_wdata_o !== h_wdata || host_be_o !== 4'hF) begin
               stab_err++;
            end
            if (wait_left > 0) wait_left--;
            else begin
               host_gnt_i = 1; holding = 0;
               log_addr.push_back(host_addr_o); log_we.push_back(host_we_o);
               log_wdata.push_back(host_wdata_o);
               if (host_we_o) begin
                  mem[host_addr_o] = host_wdata_o; pend_data = 0; pend_err = 0;
               end else begin
                  read_cnt++;
                  pend_data = mem_rd(host_addr_o);
                  pend_err  = (read_cnt == err_read_n);
               end
               pend = 1; pend_wait = rv_extra;
            end
         end else begin
            holding = 0;
         end
      end
   end

   task automatic cfg_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output logic rv);
      @(negedge clk_i);
      cfg_req_i = 1; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wdata; cfg_be_i = be;
      @(negedge clk_i);
      rv = cfg_rvalid_o; rdata = cfg_rdata_o; err = cfg_err_o;
      cfg_req_i = 0; cfg_we_i = 0;
   endtask

   task automatic clear_log();
      log_addr.delete(); log_we.delete(); log_wdata.delete();
      read_cnt = 0; stab_err = 0;
   endtask

   task automatic wait_log(input int n, input int bound);
      int k;
      k = 0;
      while (log_we.size() < n && k < bound) begin
         @(posedge clk_i); #1; k++;
      end
      checks++;
      if (log_we.size() < n) begin
         errors++; $display("FAIL wait_log: got %0d transactions, required %0d", log_we.size(), n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      checks++;
      if ({host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o} !== 70'd0) begin
         errors++; $display("FAIL reset_host: got req=%b we=%b be=%h addr=%h wdata=%h, required all 0",
                             host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o);
      end
      checks++;
      if ({cfg_rvalid_o, cfg_rdata_o, cfg_err_o, irq_o} !== 35'd0) begin
         errors++; $display("FAIL reset_cfg: got rv=%b rdata=%h err=%b irq=%b, required all 0",
                             cfg_rvalid_o, cfg_rdata_o, cfg_err_o, irq_o);
      end
      rst_i = 0;
   endtask

   task automatic test_regs();
      logic [31:0] rd; logic er, rv;
      cfg_acc(0, 32'h10, 0, 4'hF, rd, er, rv);
      checks++;
      if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
         errors++; $display("FAIL status_after_reset: got rv=%b err=%b data=%h, required 1 0 00000000", rv, er, rd);
      end
      cfg_acc(1, 32'h00, 32'hFFFF_FFFF, 4'b0101, rd, er, rv);
      cfg_acc(0, 32'h00, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h00FF_00FC) begin
         errors++; $display("FAIL src_be_write: got %h, required 00ff00fc", rd);
      end
      cfg_acc(1, 32'h04, 32'h1234_5677, 4'hF, rd, er, rv);
      cfg_acc(0, 32'h04, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h1234_5674) begin
         errors++; $display("FAIL dst_align: got %h, required 12345674", rd);
      end
      cfg_acc(1, 32'h08, 32'hFFFF_FFFF, 4'hF, rd, er, rv);
      cfg_acc(0, 32'h08, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h0000_FFFF) begin
         errors++; $display("FAIL len_zext: got %h, required 0000ffff", rd);
      end
      cfg_acc(1, 32'h0C, 32'h2, 4'hF, rd, er, rv);
      cfg_acc(0, 32'h0C, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h2) begin
         errors++; $display("FAIL ctrl_irq_en: got %h, required 00000002", rd);
      end
      cfg_acc(1, 32'h0C, 32'h0, 4'hF, rd, er, rv);
   endtask

   task automatic test_copy3();
      logic [31:0] rd, ea; logic er, rv;
      logic [31:0] words [3];
      words[0] = 32'hDEAD_0001; words[1] = 32'hCAFE_0002; words[2] = 32'hBEEF_0003;
      for (int k = 0; k < 3; k++) mem[32'h0010_0000 + 32'(4*k)] = words[k];
      clear_log();
      cfg_acc(1, 32'h00, 32'h0010_0000, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h04, 32'h0010_0100, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h08, 32'd3, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h0C, 32'h1, 4'hF, rd, er, rv);
      wait_log(6, 200);
      repeat (3) @(posedge clk_i);
      checks++;
      if (log_we.size() != 6) begin
         errors++; $display("FAIL copy3_count: got %0d transactions, required 6", log_we.size());
      end
      for (int i = 0; i < 6 && i < log_we.size(); i++) begin
         ea = ((i % 2) == 1) ? 32'h0010_0100 + 32'(4*(i/2)) : 32'h0010_0000 + 32'(4*(i/2));
         checks++;
         if (log_we[i] !== ((i % 2) == 1) || log_addr[i] !== ea) begin
            errors++; $display("FAIL copy3_txn%0d: got we=%b addr=%h, required we=%0d addr=%h",
                               i, log_we[i], log_addr[i], i % 2, ea);
         end
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (mem_rd(32'h0010_0100 + 32'(4*k)) !== words[k]) begin
            errors++; $display("FAIL copy3_data%0d: got %h, required %h", k,
                               mem_rd(32'h0010_0100 + 32'(4*k)), words[k]);
         end
      end
      cfg_acc(0, 32'h10, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h2 || irq_o !== 1'b0) begin
         errors++; $display("FAIL copy3_status: got status=%h irq=%b, required 00000002 0", rd, irq_o);
      end
   endtask

   task automatic test_len0();
      logic [31:0] rd; logic er, rv;
      clear_log();
      cfg_acc(1, 32'h08, 32'd0, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h10, 32'h6, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h0C, 32'h3, 4'hF, rd, er, rv);
      checks++;
      if (irq_o !== 1'b1 || host_req_o !== 1'b0) begin
         errors++; $display("FAIL len0_irq: got irq=%b req=%b, required 1 0", irq_o, host_req_o);
      end
      cfg_acc(0, 32'h10, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h2 || log_we.size() != 0) begin
         errors++; $display("FAIL len0_status: got status=%h txns=%0d, required 00000002 0", rd, log_we.size());
      end
      cfg_acc(1, 32'h10, 32'h2, 4'hF, rd, er, rv);
      checks++;
      if (irq_o !== 1'b0) begin
         errors++; $display("FAIL len0_w1c_irq: got irq=%b, required 0", irq_o);
      end
   endtask

   task automatic test_gnt_delay();
      logic [31:0] rd; logic er, rv;
      clear_log();
      gnt_max = 5;
      cfg_acc(1, 32'h00, 32'h0000_2000, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h04, 32'h0000_3000, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h08, 32'd4, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h0C, 32'h1, 4'hF, rd, er, rv);
      wait_log(8, 400);
      repeat (4) @(posedge clk_i);
      gnt_max = 0;
      checks++;
      if (stab_err != 0 || log_we.size() != 8) begin
         errors++; $display("FAIL gnt_stable: got unstable=%0d txns=%0d, required 0 8", stab_err, log_we.size());
      end
      checks++;
      if (dut.cnt_q !== 16'd0) begin
         errors++; $display("FAIL gnt_count: got %0d, required 0", dut.cnt_q);
      end
      checks++;
      if (mem_rd(32'h0000_300C) !== 32'h5A5A_200C) begin
         errors++; $display("FAIL gnt_data: got %h, required 5a5a200c", mem_rd(32'h0000_300C));
      end
      cfg_acc(0, 32'h10, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h2) begin
         errors++; $display("FAIL gnt_status: got %h, required 00000002", rd);
      end
   endtask

   task automatic test_err();
      logic [31:0] rd; logic er, rv;
      int nw;
      clear_log();
      err_read_n = 2;
      cfg_acc(1, 32'h00, 32'h0000_4000, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h04, 32'h0000_5000, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h08, 32'd4, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h0C, 32'h1, 4'hF, rd, er, rv);
      wait_log(3, 200);
      repeat (8) @(posedge clk_i);
      err_read_n = 0;
      nw = 0;
      foreach (log_we[i]) if (log_we[i]) nw++;
      checks++;
      if (log_we.size() != 3 || nw != 1) begin
         errors++; $display("FAIL err_txns: got %0d txns %0d writes, required 3 1", log_we.size(), nw);
      end
      cfg_acc(0, 32'h10, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h6) begin
         errors++; $display("FAIL err_status: got %h, required 00000006", rd);
      end
      cfg_acc(1, 32'h10, 32'h6, 4'hF, rd, er, rv);
      cfg_acc(0, 32'h10, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL err_w1c: got %h, required 00000000", rd);
      end
   endtask

   task automatic test_busy_write();
      logic [31:0] rd; logic er, rv;
      clear_log();
      cfg_acc(1, 32'h00, 32'h0000_6000, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h04, 32'h0000_7000, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h08, 32'd4, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h0C, 32'h1, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h00, 32'h0000_9000, 4'hF, rd, er, rv);
      checks++;
      if (rv !== 1'b1 || er !== 1'b1) begin
         errors++; $display("FAIL busy_src_err: got rv=%b err=%b, required 1 1", rv, er);
      end
      cfg_acc(0, 32'h00, 0, 4'hF, rd, er, rv);
      checks++;
      if (rd !== 32'h0000_6000 || er !== 1'b0) begin
         errors++; $display("FAIL busy_src_keep: got %h err=%b, required 00006000 0", rd, er);
      end
      cfg_acc(0, 32'h14, 0, 4'hF, rd, er, rv);
      checks++;
      if (rv !== 1'b1 || er !== 1'b1) begin
         errors++; $display("FAIL unmapped_err: got rv=%b err=%b, required 1 1", rv, er);
      end
      wait_log(8, 200);
      repeat (4) @(posedge clk_i);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er, rv;
      clear_log();
      rv_extra = 1;
      cfg_acc(1, 32'h00, 32'h0000_8000, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h04, 32'h0000_8800, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h08, 32'd2, 4'hF, rd, er, rv);
      cfg_acc(1, 32'h0C, 32'h3, 4'hF, rd, er, rv);
      wait_log(2, 200);
      @(negedge clk_i); rst_i = 1;
      @(negedge clk_i); rst_i = 0;
      rv_extra = 0;
      repeat (4) @(negedge clk_i);
      checks++;
      if (host_req_o !== 1'b0 || irq_o !== 1'b0 || log_we.size() != 2) begin
         errors++; $display("FAIL rstmid_idle: got req=%b irq=%b txns=%0d, required 0 0 2",
                            host_req_o, irq_o, log_we.size());
      end
      for (int k = 0; k < 5; k++) begin
         cfg_acc(0, 32'(4*k), 0, 4'hF, rd, er, rv);
         checks++;
         if (rd !== 32'h0) begin
            errors++; $display("FAIL rstmid_reg%0d: got %h, required 00000000", k, rd);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      checks = 0; errors = 0;
      gnt_max = 0; rv_extra = 0; err_read_n = 0; read_cnt = 0; stab_err = 0;
      rst_i = 1; cfg_req_i = 0; cfg_we_i = 0; cfg_be_i = 0; cfg_addr_i = 0; cfg_wdata_i = 0;
      test_reset();
      test_regs();
      test_copy3();
      test_len0();
      test_gnt_delay();
      test_err();
      test_busy_write();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
